datapath_sequencer: RTL and testbench
=====================================

DATAPATH_SEQUENCER -- requirements
Module: datapath_sequencer

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high; sampled only on rising clk.
REQ-003 start  input  1  request to execute instr_in; honoured only while w=1.
REQ-004 instr_in  input  16  instruction word: opcode[15:13], op[12:11], Rn[10:8], Rd[7:5], sh[4:3], Rm[2:0], imm8[7:0].
REQ-005 w  output  1  ready; high only in state WAIT.
REQ-006 err  output  1  one-cycle pulse on an unsupported instruction.
REQ-007 readnum, writenum  output  3 each  register file read/write index to the datapath.
REQ-008 write, vsel, loada, loadb, asel, bsel, loadc, loads  output  1 each  datapath controls; vsel=1 selects datapath_in, vsel=0 selects C.
REQ-009 shift, ALUop  output  2 each  datapath shifter and ALU controls; ALUop 00 ADD, 01 SUB, 10 AND, 11 NOT B.
REQ-010 datapath_in  output  16  sign-extended imm8, {{8{imm8[7]}},imm8}, taken from the latched instruction.

Function
REQ-011 The block SHALL latch instr_in into an internal 16-bit IR on the rising edge where state=WAIT and start=1; IR SHALL hold otherwise.
REQ-012 start SHALL be ignored in every state other than WAIT; IR and state SHALL be unaffected by it.
REQ-013 States SHALL be WAIT, DECODE, GET_A, GET_B, EXEC, WR_REG, WR_IMM.
REQ-014 All outputs SHALL be Moore outputs (a function of state and IR only); every control not listed for a state SHALL be 0.
REQ-015 WAIT: w=1; start=1 moves to DECODE, otherwise stays in WAIT.
REQ-016 DECODE transitions:
- opcode=110, op=10 (MOV imm) -> WR_IMM
- opcode=110, op=00 (MOV reg) -> GET_B
- opcode=101, op=11 (MVN) -> GET_B
- opcode=101, other op (ADD/CMP/AND) -> GET_A
- any other encoding -> WAIT with err=1 for the DECODE cycle; no register write occurs.
REQ-017 GET_A: readnum=Rn, loada=1; next state GET_B.
REQ-018 GET_B: readnum=Rm, loadb=1; next state EXEC.
REQ-019 EXEC: shift=sh, bsel=0.
- MOV reg: asel=1, ALUop=00, loadc=1.
- MVN: asel=1, ALUop=11, loadc=1.
- ADD: asel=0, ALUop=00, loadc=1.
- AND: asel=0, ALUop=10, loadc=1.
- CMP: asel=0, ALUop=01, loads=1, loadc=0; next state WAIT.
- All other instructions: next state WR_REG.
REQ-020 WR_REG: writenum=Rd, vsel=0, write=1; next state WAIT.
REQ-021 WR_IMM: writenum=Rn, vsel=1, write=1; next state WAIT.
REQ-022 Latency, counted in edges after the start-sampling edge until state=WAIT again:
- MOV imm 3; MOV reg/MVN 5; ADD/AND 6; CMP 5; unsupported 2.
REQ-023 start held high continuously SHALL begin a new instruction on each visit to WAIT, giving exactly one WAIT cycle between instructions.

Reset
REQ-024 reset=1 at a rising edge SHALL force state=WAIT and IR=16'h0000 from any state, including mid-instruction; no write occurs in the cycle following that edge.
REQ-025 After reset: w=1, err=0, every control=0, datapath_in=16'h0000.
REQ-026 reset SHALL take priority over start on the same edge.

Verification
REQ-027 Reset, then start with 16'hD105 (MOV R1,#5) -> WR_IMM 2 edges later: write=1, writenum=1, vsel=1, datapath_in=16'h0005; w=1 on the 3rd edge.
REQ-028 Start with 16'hD0FF (MOV R0,#-1) -> datapath_in=16'hFFFF during WR_IMM.
REQ-029 Start with 16'hA141 (ADD R2,R1,R1) -> GET_A readnum=1 loada=1; GET_B readnum=1 loadb=1; EXEC ALUop=00 asel=0 loadc=1; WR_REG writenum=2 write=1; w returns after 6 edges.
REQ-030 Start with 16'hA901 (CMP R1,R1) -> EXEC ALUop=01 loads=1 loadc=0; write stays 0 throughout; w returns after 5 edges.
REQ-031 Start with 16'hE000 -> err=1 for exactly one cycle, write=0 throughout, w=1 after 2 edges.
REQ-032 Start ADD, assert reset during EXEC -> next edge state=WAIT, write never asserted; start pulsed during GET_A of another ADD is ignored (IR unchanged).

Source files
------------

// File: rtl/datapath_sequencer.sv
// Instruction sequencer for a simple register-file/ALU datapath: latches one
// instruction from WAIT and steps the datapath controls through its phases.
module datapath_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] instr_in,
  output logic        w,
  output logic        err,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        vsel,
  output logic        loada,
  output logic        loadb,
  output logic        asel,
  output logic        bsel,
  output logic        loadc,
  output logic        loads,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] datapath_in
);

  typedef enum logic [2:0] {
    S_WAIT, S_DECODE, S_GET_A, S_GET_B, S_EXEC, S_WR_REG, S_WR_IMM
  } state_t;

  typedef enum logic [2:0] {
    C_BAD, C_MOVI, C_MOVR, C_MVN, C_ADD, C_CMP, C_AND
  } cls_t;

  typedef struct packed {
    logic        w;
    logic        err;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        vsel;
    logic        loada;
    logic        loadb;
    logic        asel;
    logic        bsel;
    logic        loadc;
    logic        loads;
    logic [1:0]  shift;
    logic [1:0]  aluop;
    logic [15:0] dp;
  } ctrl_t;

  state_t      state, state_nx;
  logic [15:0] ir, ir_nx;
  ctrl_t       ctrl_q;

  function automatic cls_t classify(input logic [15:0] i);
    cls_t c;
    case ({i[15:13], i[12:11]})
      5'b110_10: c = C_MOVI;
      5'b110_00: c = C_MOVR;
      5'b101_11: c = C_MVN;
      5'b101_00: c = C_ADD;
      5'b101_01: c = C_CMP;
      5'b101_10: c = C_AND;
      default:   c = C_BAD;
    endcase
    return c;
  endfunction

  // Controls are a pure function of (state, IR); evaluating it on the next
  // state lets the outputs come straight from flops without extra latency.
  function automatic ctrl_t decode_ctrl(input state_t s, input logic [15:0] i);
    ctrl_t c;
    cls_t  k;
    k    = classify(i);
    c    = '0;
    c.dp = {{8{i[7]}}, i[7:0]};
    case (s)
      S_WAIT:   c.w = 1'b1;
      S_DECODE: c.err = (k == C_BAD);
      S_GET_A:  begin c.readnum = i[10:8]; c.loada = 1'b1; end
      S_GET_B:  begin c.readnum = i[2:0];  c.loadb = 1'b1; end
      S_EXEC: begin
        c.shift = i[4:3];
        c.bsel  = 1'b0;
        case (k)
          C_MOVR:  begin c.asel = 1'b1; c.aluop = 2'b00; c.loadc = 1'b1; end
          C_MVN:   begin c.asel = 1'b1; c.aluop = 2'b11; c.loadc = 1'b1; end
          C_ADD:   begin c.aluop = 2'b00; c.loadc = 1'b1; end
          C_AND:   begin c.aluop = 2'b10; c.loadc = 1'b1; end
          C_CMP:   begin c.aluop = 2'b01; c.loads = 1'b1; end
          default: ;
        endcase
      end
      S_WR_REG: begin c.writenum = i[7:5];  c.write = 1'b1; end
      S_WR_IMM: begin c.writenum = i[10:8]; c.vsel = 1'b1; c.write = 1'b1; end
      default:  ;
    endcase
    return c;
  endfunction

  always_comb begin
    state_nx = state;
    ir_nx    = ir;
    case (state)
      S_WAIT: if (start) begin
        state_nx = S_DECODE;
        ir_nx    = instr_in;
      end
      S_DECODE: case (classify(ir))
        C_MOVI:              state_nx = S_WR_IMM;
        C_MOVR, C_MVN:       state_nx = S_GET_B;
        C_ADD, C_CMP, C_AND: state_nx = S_GET_A;
        default:             state_nx = S_WAIT;
      endcase
      S_GET_A:  state_nx = S_GET_B;
      S_GET_B:  state_nx = S_EXEC;
      S_EXEC:   state_nx = (classify(ir) == C_CMP) ? S_WAIT : S_WR_REG;
      default:  state_nx = S_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_WAIT;
      ir     <= '0;
      ctrl_q <= decode_ctrl(S_WAIT, 16'h0000);
    end else begin
      state  <= state_nx;
      ir     <= ir_nx;
      ctrl_q <= decode_ctrl(state_nx, ir_nx);
    end
  end

  assign w           = ctrl_q.w;
  assign err         = ctrl_q.err;
  assign readnum     = ctrl_q.readnum;
  assign writenum    = ctrl_q.writenum;
  assign write       = ctrl_q.write;
  assign vsel        = ctrl_q.vsel;
  assign loada       = ctrl_q.loada;
  assign loadb       = ctrl_q.loadb;
  assign asel        = ctrl_q.asel;
  assign bsel        = ctrl_q.bsel;
  assign loadc       = ctrl_q.loadc;
  assign loads       = ctrl_q.loads;
  assign shift       = ctrl_q.shift;
  assign ALUop       = ctrl_q.aluop;
  assign datapath_in = ctrl_q.dp;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench: directed and randomized instructions compared cycle by
// cycle against a per-instruction expected control trace.
module tb_datapath_sequencer;

  logic        clk, reset, start;
  logic [15:0] instr_in;
  logic        w, err, write, vsel, loada, loadb, asel, bsel, loadc, loads;
  logic [2:0]  readnum, writenum;
  logic [1:0]  shift, ALUop;
  logic [15:0] datapath_in;

  datapath_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .instr_in(instr_in),
    .w(w), .err(err), .readnum(readnum), .writenum(writenum),
    .write(write), .vsel(vsel), .loada(loada), .loadb(loadb),
    .asel(asel), .bsel(bsel), .loadc(loadc), .loads(loads),
    .shift(shift), .ALUop(ALUop), .datapath_in(datapath_in)
  );

  typedef struct packed {
    logic        w;
    logic        err;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        vsel;
    logic        loada;
    logic        loadb;
    logic        asel;
    logic        bsel;
    logic        loadc;
    logic        loads;
    logic [1:0]  shift;
    logic [1:0]  aluop;
    logic [15:0] dp;
  } ov_t;

  ov_t obs;
  assign obs = {w, err, readnum, writenum, write, vsel, loada, loadb,
                asel, bsel, loadc, loads, shift, ALUop, datapath_in};

  int  checks = 0;
  int  errors = 0;
  ov_t exp_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input ov_t e, input string tag);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, e);
    end
  endtask

  // Expected output for every cycle after the start-sampling edge, ending
  // with the first cycle back in WAIT. Built from the instruction's meaning.
  function automatic void build(input logic [15:0] i);
    ov_t base, v;
    logic [2:0] rn, rd, rm;
    logic is_movi, is_movr, is_mvn, is_add, is_cmp, is_and, bad;
    rn = i[10:8]; rd = i[7:5]; rm = i[2:0];
    is_movi = (i[15:13] == 3'b110) && (i[12:11] == 2'b10);
    is_movr = (i[15:13] == 3'b110) && (i[12:11] == 2'b00);
    is_mvn  = (i[15:13] == 3'b101) && (i[12:11] == 2'b11);
    is_add  = (i[15:13] == 3'b101) && (i[12:11] == 2'b00);
    is_cmp  = (i[15:13] == 3'b101) && (i[12:11] == 2'b01);
    is_and  = (i[15:13] == 3'b101) && (i[12:11] == 2'b10);
    bad     = !(is_movi || is_movr || is_mvn || is_add || is_cmp || is_and);
    exp_q.delete();
    base    = '0;
    base.dp = (i[7] ? 16'hFF00 : 16'h0000) | {8'h00, i[7:0]};
    v = base; v.err = bad; exp_q.push_back(v);
    if (is_movi) begin
      v = base; v.writenum = rn; v.vsel = 1'b1; v.write = 1'b1;
      exp_q.push_back(v);
    end else if (!bad) begin
      if (is_add || is_cmp || is_and) begin
        v = base; v.readnum = rn; v.loada = 1'b1; exp_q.push_back(v);
      end
      v = base; v.readnum = rm; v.loadb = 1'b1; exp_q.push_back(v);
      v = base; v.shift = i[4:3];
      v.asel  = is_movr || is_mvn;
      v.aluop = is_mvn ? 2'd3 : is_and ? 2'd2 : is_cmp ? 2'd1 : 2'd0;
      v.loadc = !is_cmp;
      v.loads = is_cmp;
      exp_q.push_back(v);
      if (!is_cmp) begin
        v = base; v.writenum = rd; v.write = 1'b1; exp_q.push_back(v);
      end
    end
    v = base; v.w = 1'b1; exp_q.push_back(v);
  endfunction

  // mode 0: start dropped after issue; 1: start forced high with junk instr
  // mid-flight; 2: start and instr held high throughout; 3: random noise.
  task automatic run_instr(input logic [15:0] i, input int mode);
    int n;
    build(i);
    n        = exp_q.size();
    start    = 1'b1;
    instr_in = i;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      check(exp_q[k], $sformatf("i%h_c%0d", i, k));
      if (k == n - 1) start = (mode == 2);
      else case (mode)
        0: start = 1'b0;
        1: begin start = 1'b1; instr_in = 16'($urandom); end
        2: ;
        default: begin start = 1'($urandom); instr_in = 16'($urandom); end
      endcase
    end
  endtask

  ov_t rst_v;
  logic [15:0] ri;

  initial begin
    rst_v = '0; rst_v.w = 1'b1;
    reset = 1'b1; start = 1'b0; instr_in = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check(rst_v, "reset_state");
    reset = 1'b0;

    // directed instructions
    run_instr(16'hD105, 0);   // MOV R1,#5
    run_instr(16'hD0FF, 0);   // MOV R0,#-1
    run_instr(16'hA141, 1);   // ADD R2,R1,R1 with start noise mid-flight
    run_instr(16'hA901, 0);   // CMP R1,R1
    run_instr(16'hE000, 0);   // unsupported
    run_instr(16'hC06A, 0);   // MOV R3,R2,sh1
    run_instr(16'hB893, 0);   // MVN
    run_instr(16'hB223, 0);   // AND
    run_instr(16'hC800, 0);   // unsupported within opcode 110
    run_instr(16'hD800, 0);

    // start held high back to back: one WAIT cycle between instructions
    run_instr(16'hA141, 2);
    run_instr(16'hD17F, 2);
    run_instr(16'hA901, 2);
    start = 1'b0;
    @(posedge clk); #1;
    check(exp_q[exp_q.size()-1], "idle_after_chain");

    // reset during EXEC of an ADD
    build(16'hA141);
    start = 1'b1; instr_in = 16'hA141;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check(exp_q[k], $sformatf("rst_add_c%0d", k));
      start = 1'b0;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    check(rst_v, "reset_mid_exec");
    reset = 1'b0;
    @(posedge clk); #1;
    check(rst_v, "post_reset_idle");

    // reset wins over start on the same edge
    reset = 1'b1; start = 1'b1; instr_in = 16'hA141;
    @(posedge clk); #1;
    check(rst_v, "reset_over_start");
    reset = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check(rst_v, "no_decode_after_reset");

    // randomized instructions, biased toward supported opcodes
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 3))
        0:       ri = {3'b101, 13'($urandom)};
        1:       ri = {3'b110, 13'($urandom)};
        default: ri = 16'($urandom);
      endcase
      run_instr(ri, int'($urandom_range(0, 3)));
    end
    start = 1'b0;
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
